// File: rtl/pipeline_latch_unit_pkg.sv
// +----------------------------------------------------------------------------+
// | pipeline_latch_unit_pkg                                                    |
// | Shared SimpleRISC encodings, field slices and OF source-usage decode.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package pipeline_latch_unit_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_MUL  = 5'b00010;
  localparam logic [4:0] OP_DIV  = 5'b00011;
  localparam logic [4:0] OP_MOD  = 5'b00100;
  localparam logic [4:0] OP_CMP  = 5'b00101;
  localparam logic [4:0] OP_AND  = 5'b00110;
  localparam logic [4:0] OP_OR   = 5'b00111;
  localparam logic [4:0] OP_NOT  = 5'b01000;
  localparam logic [4:0] OP_MOV  = 5'b01001;
  localparam logic [4:0] OP_LSL  = 5'b01010;
  localparam logic [4:0] OP_LSR  = 5'b01011;
  localparam logic [4:0] OP_ASR  = 5'b01100;
  localparam logic [4:0] OP_NOP  = 5'b01101;
  localparam logic [4:0] OP_LD   = 5'b01110;
  localparam logic [4:0] OP_ST   = 5'b01111;
  localparam logic [4:0] OP_BEQ  = 5'b10000;
  localparam logic [4:0] OP_BGT  = 5'b10001;
  localparam logic [4:0] OP_B    = 5'b10010;
  localparam logic [4:0] OP_CALL = 5'b10011;
  localparam logic [4:0] OP_RET  = 5'b10100;

  localparam int OPC_HI  = 31;
  localparam int OPC_LO  = 27;
  localparam int IMM_BIT = 26;
  localparam int RD_HI   = 25;
  localparam int RD_LO   = 22;
  localparam int RS1_HI  = 21;
  localparam int RS1_LO  = 18;
  localparam int RS2_HI  = 17;
  localparam int RS2_LO  = 14;

  localparam logic [31:0] NOP_IR = 32'h6800_0000;
  localparam logic [3:0]  RA_REG = 4'd15;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] pc;
    logic        valid;
  } stage_t;

  localparam stage_t STAGE_BUBBLE = '{ir: NOP_IR, pc: 32'd0, valid: 1'b0};

  function automatic logic [4:0] get_opcode(input logic [31:0] ir);
    return ir[OPC_HI:OPC_LO];
  endfunction

  function automatic logic [3:0] get_rd(input logic [31:0] ir);
    return ir[RD_HI:RD_LO];
  endfunction

  // ret carries no rs1 field; it implicitly reads the return-address register.
  function automatic logic [3:0] get_rs1(input logic [31:0] ir);
    return (ir[OPC_HI:OPC_LO] == OP_RET) ? RA_REG : ir[RS1_HI:RS1_LO];
  endfunction

  function automatic logic [3:0] get_rs2(input logic [31:0] ir);
    return ir[RS2_HI:RS2_LO];
  endfunction

  function automatic logic uses_rs1(input logic [31:0] ir);
    logic r;
    case (ir[OPC_HI:OPC_LO])
      OP_NOP, OP_B, OP_BEQ, OP_BGT, OP_CALL, OP_NOT, OP_MOV: r = 1'b0;
      default:                                              r = 1'b1;
    endcase
    return r;
  endfunction

  function automatic logic uses_rs2(input logic [31:0] ir);
    return (ir[IMM_BIT] == 1'b0) && (ir[OPC_HI:OPC_LO] <= OP_ASR);
  endfunction

  function automatic logic reads_rd(input logic [31:0] ir);
    return ir[OPC_HI:OPC_LO] == OP_ST;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipeline_latch_unit_load_use_detect.sv
// +----------------------------------------------------------------------------+
// | load_use_detect                                                            |
// | Flags a load in EX whose destination is a live source of the OF stage.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module load_use_detect
  import pipeline_latch_unit_pkg::*;
(
  input  logic [31:0] of_ir,
  input  logic        of_valid,
  input  logic [31:0] ex_ir,
  input  logic        ex_valid,
  output logic        hit
);

  logic [3:0] w_ld_rd;
  logic       w_ex_load;
  logic       w_rs1_hit;
  logic       w_rs2_hit;
  logic       w_rd_hit;

  assign w_ld_rd   = get_rd(ex_ir);
  assign w_ex_load = ex_valid && (get_opcode(ex_ir) == OP_LD);
  assign w_rs1_hit = uses_rs1(of_ir) && (get_rs1(of_ir) == w_ld_rd);
  assign w_rs2_hit = uses_rs2(of_ir) && (get_rs2(of_ir) == w_ld_rd);
  assign w_rd_hit  = reads_rd(of_ir) && (get_rd(of_ir) == w_ld_rd);
  assign hit       = w_ex_load && of_valid && (w_rs1_hit || w_rs2_hit || w_rd_hit);

endmodule

`default_nettype wire

// File: rtl/pipeline_latch_unit.sv
// +----------------------------------------------------------------------------+
// | pipeline_latch_unit                                                        |
// | OF/EX/MA/RW latches with load-use interlock, branch flush, memory hold.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module pipeline_latch_unit
  import pipeline_latch_unit_pkg::*;
#(
  parameter int CNT_W = 16
)
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      if_ir,
  input  logic [31:0]      if_pc,
  input  logic             if_valid,
  input  logic             branch_taken,
  input  logic             mem_hold,
  output logic [31:0]      of_ir,
  output logic [31:0]      ex_ir,
  output logic [31:0]      ma_ir,
  output logic [31:0]      rw_ir,
  output logic [31:0]      of_pc,
  output logic [31:0]      ex_pc,
  output logic [31:0]      ma_pc,
  output logic [31:0]      rw_pc,
  output logic             of_valid,
  output logic             ex_valid,
  output logic             ma_valid,
  output logic             rw_valid,
  output logic             if_stall,
  output logic             interlock,
  output logic [CNT_W-1:0] interlock_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       r_rst_sync;
  logic             w_rst_n;
  stage_t           r_of;
  stage_t           r_ex;
  stage_t           r_ma;
  stage_t           r_rw;
  stage_t           w_if;
  logic             w_hit;
  logic             w_interlock;
  logic [CNT_W-1:0] r_icnt;
  logic [CNT_W-1:0] r_fcnt;

  // Reset asserts immediately but is released only on a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_rst_n = r_rst_sync[1];

  load_use_detect u_load_use_detect (
    .of_ir    (r_of.ir),
    .of_valid (r_of.valid),
    .ex_ir    (r_ex.ir),
    .ex_valid (r_ex.valid),
    .hit      (w_hit)
  );

  assign w_interlock = w_hit && !mem_hold && !branch_taken;
  assign if_stall    = mem_hold || w_interlock;
  assign interlock   = w_interlock;

  // Invalid fetch slots enter OF as a canonical NOP so forwarding sees no rd.
  always_comb begin
    w_if.ir    = if_valid ? if_ir : NOP_IR;
    w_if.pc    = if_pc;
    w_if.valid = if_valid;
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_of <= STAGE_BUBBLE;
      r_ex <= STAGE_BUBBLE;
      r_ma <= STAGE_BUBBLE;
      r_rw <= STAGE_BUBBLE;
    end else if (mem_hold) begin
      r_of <= r_of;
      r_ex <= r_ex;
      r_ma <= r_ma;
      r_rw <= r_rw;
    end else if (branch_taken) begin
      r_of <= STAGE_BUBBLE;
      r_ex <= STAGE_BUBBLE;
      r_ma <= r_ex;
      r_rw <= r_ma;
    end else if (w_interlock) begin
      r_of <= r_of;
      r_ex <= STAGE_BUBBLE;
      r_ma <= r_ex;
      r_rw <= r_ma;
    end else begin
      r_of <= w_if;
      r_ex <= r_of;
      r_ma <= r_ex;
      r_rw <= r_ma;
    end
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_icnt <= '0;
      r_fcnt <= '0;
    end else if (!mem_hold) begin
      if (branch_taken && (r_fcnt != '1)) r_fcnt <= r_fcnt + C_CNT_ONE;
      if (w_interlock && (r_icnt != '1))  r_icnt <= r_icnt + C_CNT_ONE;
    end
  end

  assign of_ir         = r_of.ir;
  assign ex_ir         = r_ex.ir;
  assign ma_ir         = r_ma.ir;
  assign rw_ir         = r_rw.ir;
  assign of_pc         = r_of.pc;
  assign ex_pc         = r_ex.pc;
  assign ma_pc         = r_ma.pc;
  assign rw_pc         = r_rw.pc;
  assign of_valid      = r_of.valid;
  assign ex_valid      = r_ex.valid;
  assign ma_valid      = r_ma.valid;
  assign rw_valid      = r_rw.valid;
  assign interlock_cnt = r_icnt;
  assign flush_cnt     = r_fcnt;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_latch_unit.sv
// +----------------------------------------------------------------------------+
// | tb_pipeline_latch_unit                                                     |
// | Scoreboarded random/directed bench against a stage-slot reference model.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_pipeline_latch_unit;

  // Narrowed counters keep the saturation run short; the logic is width-generic.
  localparam int CW   = 12;
  localparam int MAXC = (1 << CW) - 1;
  localparam logic [31:0] NOP = 32'h6800_0000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   if_ir, if_pc;
  logic          if_valid, branch_taken, mem_hold;
  logic [31:0]   of_ir, ex_ir, ma_ir, rw_ir, of_pc, ex_pc, ma_pc, rw_pc;
  logic          of_valid, ex_valid, ma_valid, rw_valid, if_stall, interlock;
  logic [CW-1:0] interlock_cnt, flush_cnt;

  always #5 clk = ~clk;

  pipeline_latch_unit #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .if_ir(if_ir), .if_pc(if_pc), .if_valid(if_valid),
    .branch_taken(branch_taken), .mem_hold(mem_hold),
    .of_ir(of_ir), .ex_ir(ex_ir), .ma_ir(ma_ir), .rw_ir(rw_ir),
    .of_pc(of_pc), .ex_pc(ex_pc), .ma_pc(ma_pc), .rw_pc(rw_pc),
    .of_valid(of_valid), .ex_valid(ex_valid), .ma_valid(ma_valid), .rw_valid(rw_valid),
    .if_stall(if_stall), .interlock(interlock),
    .interlock_cnt(interlock_cnt), .flush_cnt(flush_cnt)
  );

  typedef struct packed {
    logic [3:0][31:0] ir;
    logic [3:0][31:0] pc;
    logic [3:0]       v;
    logic [CW-1:0]    icnt;
    logic [CW-1:0]    fcnt;
    logic             stall;
    logic             il;
  } snap_t;

  snap_t q_exp[$];
  int    n_checks = 0;
  int    n_err    = 0;

  // Reference model: slot 0..3 = OF, EX, MA, RW
  logic [31:0] m_ir[4];
  logic [31:0] m_pc[4];
  logic        m_v[4];
  int          m_icnt, m_fcnt;

  logic [31:0] d_ir[4];
  logic [31:0] d_pc[4];
  logic        d_v[4];
  assign d_ir[0] = of_ir;    assign d_ir[1] = ex_ir;    assign d_ir[2] = ma_ir;    assign d_ir[3] = rw_ir;
  assign d_pc[0] = of_pc;    assign d_pc[1] = ex_pc;    assign d_pc[2] = ma_pc;    assign d_pc[3] = rw_pc;
  assign d_v[0]  = of_valid; assign d_v[1]  = ex_valid; assign d_v[2]  = ma_valid; assign d_v[3]  = rw_valid;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_ir[i] = NOP; m_pc[i] = 32'd0; m_v[i] = 1'b0;
    end
    m_icnt = 0; m_fcnt = 0;
  endtask

  // Register numbers read by an OF instruction, listed straight from the usage rules.
  function automatic bit load_use(input logic [31:0] ex, input logic exv,
                                  input logic [31:0] of, input logic ofv);
    logic [4:0] eop, oop;
    logic [3:0] srcs[$];
    eop = ex[31:27];
    oop = of[31:27];
    if (!(exv && ofv && eop == 5'b01110)) return 1'b0;
    if (!(oop inside {5'b01101, 5'b10010, 5'b10000, 5'b10001, 5'b10011, 5'b01000, 5'b01001}))
      srcs.push_back((oop == 5'b10100) ? 4'd15 : of[21:18]);
    if (!of[26] && oop <= 5'b01100) srcs.push_back(of[17:14]);
    if (oop == 5'b01111) srcs.push_back(of[25:22]);
    foreach (srcs[k]) if (srcs[k] == ex[25:22]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] enc(input logic [4:0] op, input logic i, input logic [3:0] rd,
                                      input logic [3:0] rs1, input logic [3:0] rs2);
    return {op, i, rd, rs1, rs2, 14'd0};
  endfunction

  function automatic logic [3:0] rand_reg();
    return ($urandom_range(0, 8) == 8) ? 4'd15 : 4'($urandom_range(0, 7));
  endfunction

  function automatic logic [31:0] rand_ir();
    logic [4:0] op;
    op = ($urandom_range(0, 3) == 0) ? 5'b01110 : 5'($urandom_range(0, 20));
    return {op, 1'($urandom_range(0, 1)), rand_reg(), rand_reg(), rand_reg(), 14'($urandom)};
  endfunction

  // One clock of stimulus: drive, record expected view of this cycle, advance model.
  task automatic cyc(input logic [31:0] ir, input logic [31:0] pc, input logic v,
                     input logic bt, input logic mh);
    snap_t s;
    bit    il;
    @(posedge clk); #1;
    if_ir = ir; if_pc = pc; if_valid = v; branch_taken = bt; mem_hold = mh;
    il = load_use(m_ir[1], m_v[1], m_ir[0], m_v[0]) && !mh && !bt;
    for (int i = 0; i < 4; i++) begin
      s.ir[i] = m_ir[i]; s.pc[i] = m_pc[i]; s.v[i] = m_v[i];
    end
    s.icnt  = CW'(m_icnt);
    s.fcnt  = CW'(m_fcnt);
    s.stall = mh || il;
    s.il    = il;
    q_exp.push_back(s);
    if (mh) begin
    end else begin
      m_ir[3] = m_ir[2]; m_pc[3] = m_pc[2]; m_v[3] = m_v[2];
      m_ir[2] = m_ir[1]; m_pc[2] = m_pc[1]; m_v[2] = m_v[1];
      if (bt || il) begin
        m_ir[1] = NOP; m_pc[1] = 32'd0; m_v[1] = 1'b0;
      end else begin
        m_ir[1] = m_ir[0]; m_pc[1] = m_pc[0]; m_v[1] = m_v[0];
      end
      if (bt) begin
        m_ir[0] = NOP; m_pc[0] = 32'd0; m_v[0] = 1'b0;
        if (m_fcnt < MAXC) m_fcnt++;
      end else if (il) begin
        if (m_icnt < MAXC) m_icnt++;
      end else begin
        m_ir[0] = v ? ir : NOP; m_pc[0] = pc; m_v[0] = v;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: every cycle the DUT presents a full stage snapshot; compare to the oldest prediction.
  snap_t mon_s;
  always @(negedge clk) begin
    if (q_exp.size() > 0) begin
      mon_s = q_exp.pop_front();
      for (int i = 0; i < 4; i++) begin
        check($sformatf("ir%0d", i), d_ir[i], mon_s.ir[i]);
        check($sformatf("valid%0d", i), 32'(d_v[i]), 32'(mon_s.v[i]));
        if (mon_s.v[i]) check($sformatf("pc%0d", i), d_pc[i], mon_s.pc[i]);
      end
      check("interlock_cnt", 32'(interlock_cnt), 32'(mon_s.icnt));
      check("flush_cnt", 32'(flush_cnt), 32'(mon_s.fcnt));
      check("if_stall", 32'(if_stall), 32'(mon_s.stall));
      check("interlock", 32'(interlock), 32'(mon_s.il));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  task automatic check_reset_values(input string tag);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_ir%0d", tag, i), d_ir[i], NOP);
      check($sformatf("%s_pc%0d", tag, i), d_pc[i], 32'd0);
      check($sformatf("%s_valid%0d", tag, i), 32'(d_v[i]), 32'd0);
    end
    check({tag, "_icnt"}, 32'(interlock_cnt), 32'd0);
    check({tag, "_fcnt"}, 32'(flush_cnt), 32'd0);
  endtask

  logic [31:0] ld_r5, add_use, add_imm, st_r5, br, ld_chain;

  initial begin
    rst_n = 1'b0; if_ir = '0; if_pc = '0; if_valid = 1'b0; branch_taken = 1'b0; mem_hold = 1'b0;
    model_reset();
    ld_r5    = enc(5'b01110, 1'b1, 4'd5, 4'd2, 4'd0);
    add_use  = enc(5'b00000, 1'b0, 4'd6, 4'd5, 4'd1);
    add_imm  = enc(5'b00000, 1'b1, 4'd6, 4'd1, 4'd5) | 32'd0;
    st_r5    = enc(5'b01111, 1'b1, 4'd5, 4'd1, 4'd0);
    br       = enc(5'b10010, 1'b1, 4'd0, 4'd0, 4'd0) | 32'd64;
    ld_chain = enc(5'b01110, 1'b1, 4'd5, 4'd5, 4'd0);
    repeat (3) @(posedge clk);
    #2 check_reset_values("por");
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(posedge clk);

    // Straight-line adds
    for (int k = 0; k < 4; k++) cyc(enc(5'b00000, 1'b0, 4'd1, 4'd2, 4'd3), 32'(4 * k), 1'b1, 1'b0, 1'b0);
    idle(5);

    // Load-use on rs1
    cyc(ld_r5, 32'h100, 1'b1, 1'b0, 1'b0);
    cyc(add_use, 32'h104, 1'b1, 1'b0, 1'b0);
    idle(4);
    @(negedge clk) check("loaduse_icnt", 32'(interlock_cnt), 32'd1);

    // Immediate form does not read rs2; store reads rd
    cyc(ld_r5, 32'h200, 1'b1, 1'b0, 1'b0);
    cyc(add_imm, 32'h204, 1'b1, 1'b0, 1'b0);
    idle(4);
    cyc(ld_r5, 32'h300, 1'b1, 1'b0, 1'b0);
    cyc(st_r5, 32'h304, 1'b1, 1'b0, 1'b0);
    idle(4);
    @(negedge clk) check("store_icnt", 32'(interlock_cnt), 32'd2);

    // Taken branch in EX
    cyc(br, 32'h400, 1'b1, 1'b0, 1'b0);
    cyc(add_use, 32'h404, 1'b1, 1'b0, 1'b0);
    cyc(add_use, 32'h408, 1'b1, 1'b1, 1'b0);
    idle(4);
    @(negedge clk) check("branch_fcnt", 32'(flush_cnt), 32'd1);

    // Memory hold while ld/add sit in EX/OF, then the interlock fires once
    cyc(ld_r5, 32'h500, 1'b1, 1'b0, 1'b0);
    cyc(add_use, 32'h504, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) cyc(32'h0, 32'h508, 1'b1, 1'b0, 1'b1);
    idle(4);
    @(negedge clk) check("hold_icnt", 32'(interlock_cnt), 32'd3);

    // Randomized traffic
    for (int k = 0; k < 1500; k++)
      cyc(rand_ir(), 32'($urandom) & ~32'd3, ($urandom_range(0, 4) != 0),
          ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0));

    // Back-to-back dependent loads drive the interlock counter into saturation
    for (int k = 0; k < 2 * ((1 << CW) + 3) + 8; k++) cyc(ld_chain, 32'h600, 1'b1, 1'b0, 1'b0);
    @(negedge clk) check("sat_icnt", 32'(interlock_cnt), 32'(MAXC));

    // Asynchronous reset between clock edges
    @(posedge clk); #1;
    if_valid = 1'b0; branch_taken = 1'b0; mem_hold = 1'b0; if_pc = '0;
    #2 rst_n = 1'b0;
    #1 check_reset_values("async");
    check("async_stall", 32'(if_stall), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(posedge clk);
    model_reset();
    for (int k = 0; k < 300; k++)
      cyc(rand_ir(), 32'($urandom) & ~32'd3, ($urandom_range(0, 4) != 0),
          ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0));

    repeat (2) @(negedge clk);
    check("scoreboard_drained", 32'(q_exp.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipeline_latch_unit.md
Name: pipeline_latch_unit

Overview:
- Holds the four inter-stage instruction registers (OF, EX, MA, RW) and their PCs and valid bits for the 5-stage SimpleRISC pipeline.
- Its IR outputs feed the operand forwarding units directly.
- Detects the load-use data interlock, which forwarding cannot resolve. On an interlock it stalls IF/OF and inserts a bubble into EX.
- Applies the taken-branch flush from EX and a global memory hold.
- Keeps two saturating performance counters.

Parameters:
- NOP_IR, 32'h6800_0000, encoding injected as a bubble (opcode 01101, all other bits zero)
- RA_REG, 4'd15, return-address register used by call/ret
- CNT_W, 16, width of each performance counter

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- if_ir  in  32  instruction fetched this cycle
- if_pc  in  32  PC of if_ir
- if_valid  in  1  if_ir is a real instruction
- branch_taken  in  1  EX-stage branch/call/ret resolved taken this cycle
- mem_hold  in  1  data memory busy; freezes the whole pipe
- of_ir, ex_ir, ma_ir, rw_ir  out  32  stage instruction registers
- of_pc, ex_pc, ma_pc, rw_pc  out  32  stage PCs
- of_valid, ex_valid, ma_valid, rw_valid  out  1  stage holds a real instruction
- if_stall  out  1  fetch must hold its PC this cycle (combinational)
- interlock  out  1  load-use interlock detected this cycle (combinational)
- interlock_cnt  out  CNT_W  saturating count of interlock cycles
- flush_cnt  out  CNT_W  saturating count of branch flushes

Behaviour:
- Reset:
  - All IRs are set to NOP_IR.
  - All PCs are set to 0.
  - All valids are 0.
  - Both counters are 0.
  - Asynchronous assert, synchronous release. Reset mid-operation discards all in-flight instructions.
- Field decode:
  - Opcode is ir[31:27] and the I bit is ir[26].
  - rd = ir[25:22], rs1 = ir[21:18], rs2 = ir[17:14].
  - For ret (10100), rs1 is RA_REG.
- OF source-usage rules:
  - rs1 is used unless the opcode is nop, b, beq, bgt, call, not or mov.
  - rs2 is used when I=0 and the opcode is in 00000..01100 (the not and mov opcodes are inside this range).
  - rd is read as a source when the opcode is st (01111).
- Interlock:
  - Asserted when ex_valid=1, the ex_ir opcode is ld (01110), of_valid=1, and some used OF source equals ex_ir rd.
  - Qualified by mem_hold=0 and branch_taken=0.
- Priority per cycle: mem_hold, then branch_taken, then interlock, then normal advance.
  - mem_hold=1: every register holds, if_stall=1, and counters hold.
  - branch_taken=1:
    - EX->MA and MA->RW advance.
    - OF and EX are loaded with NOP_IR and valid 0. The instructions in IF and OF are squashed.
    - if_stall=0, because fetch redirects.
    - flush_cnt increments.
  - interlock=1:
    - OF holds and if_stall=1.
    - EX gets NOP_IR with valid 0.
    - MA and RW advance.
    - interlock_cnt increments.
    - The interlock lasts exactly one cycle, because the load then sits in MA and its result is forwarded from there.
  - Normal: IF->OF (if_ir, if_pc, if_valid), OF->EX, EX->MA, MA->RW.
- Bubble handling: when a stage has valid=0, its IR is always NOP_IR. Downstream forwarding therefore treats it as having no destination.
- Counters saturate at all-ones and do not wrap.
- Latency:
  - An instruction reaches of_ir one cycle after it is presented with if_valid.
  - It reaches rw_ir three cycles later, absent stalls.
- if_stall and interlock depend only on current register state and inputs. There is no path from if_ir to if_stall.

Decomposition:
- Shared package contents:
  - Opcode constants: OP_ADD..OP_RET, OP_NOP, OP_LD, OP_ST.
  - Field slice constants: OPC_HI/LO, RD_HI/LO, RS1_HI/LO, RS2_HI/LO, IMM_BIT.
  - NOP_IR and RA_REG.
  - Functions uses_rs1/uses_rs2/reads_rd. The forwarding units reuse these.
- One sub-module: load_use_detect, combinational. Inputs are of_ir, of_valid, ex_ir and ex_valid; output is hit. The surrounding latch/priority logic stays in the top module.

Test Plan:
- Straight-line: reset, then feed add r1,r2,r3 at PC 0, 4, 8, 12. Required: each IR appears in of_ir one cycle later and in rw_ir four cycles after presentation; valids are 1; if_stall=0 throughout; both counters stay 0.
- Load-use on rs1: ld r5,0[r2] followed by add r6,r5,r1. Required: interlock=1 and if_stall=1 for exactly one cycle; ex_ir=32'h6800_0000 with ex_valid=0 that cycle; the add is in EX the next cycle; interlock_cnt=1.
- Non-hazards:
  - ld r5 followed by add r6,r1,#5 (I=1, rs2 field 5, rs1=r1) must give interlock=0.
  - ld r5 followed by st r5,0[r1] (reads rd=r5) must give interlock=1.
- Branch flush: b in EX with branch_taken=1. Required: the next cycle has of_ir=ex_ir=NOP_IR, of_valid=ex_valid=0; the branch appears in ma_ir; flush_cnt=1.
- Hold during interlock:
  - Raise mem_hold=1 for 3 cycles while ld/add sit in EX/OF. Required: all IRs, PCs and counters are frozen, if_stall=1 and interlock=0.
  - After release, the interlock is taken exactly once.
- Async reset plus saturation:
  - Assert rst_n=0 mid-stream, not on a clock edge. Required: outputs go to reset values immediately.
  - Separately, force 2^CNT_W+3 interlocks. Required: interlock_cnt=16'hFFFF.
